// File: rtl/mult_div_unit_if.sv
// Bus between the pipeline and the multiply/divide sequencer.
// The pipeline side drives the requests and the MTHI/MTLO writes.
// The unit side returns its status and the HI/LO registers.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             hi_write;
  logic             lo_write;
  logic [WIDTH-1:0] write_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, hi_write, lo_write, write_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, hi_write, lo_write, write_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU that owns the HI/LO pair.
// A single shared datapath runs WIDTH iterations on operand magnitudes:
// shift-add for multiplies and restoring subtraction for divides.
// A FINISH cycle then applies sign correction and loads HI/LO.
// The register roles are:
//   acc_r - upper product half, or the partial remainder
//   mq_r  - the multiplier shifting out, or the dividend shifting out
//           while quotient bits shift in
//   src_r - the multiplicand, or the divisor magnitude
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  mult_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mq_r;
  logic [WIDTH-1:0] src_r;
  logic [WIDTH-1:0] dividend_r;
  logic             is_div_r;
  logic             neg_res_r;
  logic             neg_rem_r;
  logic             dbz_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_out_r;

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   acc_nxt_s;
  logic [WIDTH-1:0]   mq_nxt_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [WIDTH-1:0]   hi_fin_s;
  logic [WIDTH-1:0]   lo_fin_s;

  // Magnitude of a value that is two's complement when is_signed is set.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return ~v + ONE_W;
    end else begin
      return v;
    end
  endfunction

  // Conditional two's complement negation of a single-width value.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    if (neg) begin
      return ~v + ONE_W;
    end else begin
      return v;
    end
  endfunction

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_out_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

  // One multiply or divide iteration on the current accumulator state.
  always_comb begin
    mul_sum_s = {1'b0, acc_r} + {1'b0, (mq_r[0] ? src_r : {WIDTH{1'b0}})};
    rem_sh_s  = {acc_r, mq_r[WIDTH-1]};
    diff_s    = rem_sh_s - {1'b0, src_r};
    acc_nxt_s = acc_r;
    mq_nxt_s  = mq_r;
    if (is_div_r) begin
      // The remainder stays below the divisor, so the difference's top bit is its sign.
      if (!diff_s[WIDTH]) begin
        acc_nxt_s = diff_s[WIDTH-1:0];
        mq_nxt_s  = {mq_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt_s = rem_sh_s[WIDTH-1:0];
        mq_nxt_s  = {mq_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt_s = mul_sum_s[WIDTH:1];
      mq_nxt_s  = {mul_sum_s[0], mq_r[WIDTH-1:1]};
    end
  end

  // Sign correction and HI/LO selection applied during FINISH.
  always_comb begin
    prod_fix_s = {acc_r, mq_r};
    if (neg_res_r) begin
      prod_fix_s = ~{acc_r, mq_r} + ONE_2W;
    end else begin
      prod_fix_s = {acc_r, mq_r};
    end
    quo_fix_s = cond_neg(mq_r, neg_res_r);
    rem_fix_s = cond_neg(acc_r, neg_rem_r);
    hi_fin_s  = prod_fix_s[2*WIDTH-1:WIDTH];
    lo_fin_s  = prod_fix_s[WIDTH-1:0];
    if (dbz_r) begin
      // Division by zero returns the original dividend in HI and all ones in LO.
      hi_fin_s = dividend_r;
      lo_fin_s = {WIDTH{1'b1}};
    end else if (is_div_r) begin
      hi_fin_s = rem_fix_s;
      lo_fin_s = quo_fix_s;
    end else begin
      hi_fin_s = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_fin_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Sequencer FSM with registered status outputs and HI/LO ownership.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {WIDTH{1'b0}};
      mq_r       <= {WIDTH{1'b0}};
      src_r      <= {WIDTH{1'b0}};
      dividend_r <= {WIDTH{1'b0}};
      is_div_r   <= 1'b0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      dbz_r      <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      dbz_out_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r    <= 1'b0;
          dbz_out_r <= 1'b0;
          if (bus.start) begin
            // op[1] selects divide; op[0] clear selects the signed variant.
            is_div_r   <= bus.op[1];
            mq_r       <= bus.op[1] ? magnitude(bus.operand_a, ~bus.op[0])
                                    : magnitude(bus.operand_b, ~bus.op[0]);
            src_r      <= bus.op[1] ? magnitude(bus.operand_b, ~bus.op[0])
                                    : magnitude(bus.operand_a, ~bus.op[0]);
            neg_res_r  <= ~bus.op[0] & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
            neg_rem_r  <= ~bus.op[0] & bus.op[1] & bus.operand_a[WIDTH-1];
            dividend_r <= bus.operand_a;
            dbz_r      <= bus.op[1] & (bus.operand_b == {WIDTH{1'b0}});
            acc_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b1;
            state_r    <= ST_BUSY;
          end else begin
            // A start request takes priority, so MTHI/MTLO only apply without one.
            if (bus.hi_write) begin
              hi_r <= bus.write_data;
            end
            if (bus.lo_write) begin
              lo_r <= bus.write_data;
            end
          end
        end
        ST_BUSY: begin
          acc_r <= acc_nxt_s;
          mq_r  <= mq_nxt_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_ITER) begin
            state_r <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          hi_r      <= hi_fin_s;
          lo_r      <= lo_fin_s;
          done_r    <= 1'b1;
          dbz_out_r <= dbz_r;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          dbz_out_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases, randomized
// operations against an arithmetic reference model, handshake and MTHI/MTLO
// behaviour, and asynchronous reset during an operation.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, truncating division, remainder follows dividend.
  function automatic void ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    rz = 1'b0;
    rh = 32'd0;
    rl = 32'd0;
    if (op[1] && b == 32'd0) begin
      rz = 1'b1;
      rh = a;
      rl = 32'hFFFF_FFFF;
    end else if (op == 2'd0) begin
      p = 64'(sa * sb);
      rh = p[63:32]; rl = p[31:0];
    end else if (op == 2'd1) begin
      p = ua * ub;
      rh = p[63:32]; rl = p[31:0];
    end else if (op == 2'd2) begin
      sq = sa / sb; sr = sa % sb;
      p = 64'(sq); rl = p[31:0];
      p = 64'(sr); rh = p[31:0];
    end else begin
      uq = ua / ub; ur = ua % ub;
      rl = uq[31:0]; rh = ur[31:0];
    end
  endfunction

  // Issue one operation from a point just after a rising edge and check its result.
  // disturb: 1 = re-pulse start at cycles 5 and 32, 2 = MTHI strobe at cycle 10.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez,
                        input int disturb, input bit idle_after, input string tag);
    logic [31:0] hi_pre, lo_pre;
    int cyc;
    bit busy_ok, hold_ok;
    hi_pre = bus.hi;
    lo_pre = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.hi_write = 1'b0; bus.lo_write = 1'b0;
    bus.operand_a = $urandom; bus.operand_b = $urandom; bus.op = 2'($urandom);
    chk({tag, " busy_at_start"}, 64'(bus.busy), 64'd1);
    chk({tag, " hi_at_start"}, 64'(bus.hi), 64'(hi_pre));
    chk({tag, " lo_at_start"}, 64'(bus.lo), 64'(lo_pre));
    cyc = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      bus.start = 1'b0; bus.hi_write = 1'b0;
      if (bus.done) break;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.hi !== hi_pre || bus.lo !== lo_pre) hold_ok = 1'b0;
      if (disturb == 1 && (cyc == 5 || cyc == 32)) begin
        bus.start = 1'b1; bus.op = 2'd1;
        bus.operand_a = 32'h0000_0003; bus.operand_b = 32'h0000_0005;
      end
      if (disturb == 2 && cyc == 10) begin
        bus.hi_write = 1'b1; bus.write_data = 32'h0000_00AA;
      end
    end
    chk({tag, " latency"}, 64'(cyc), 64'd33);
    chk({tag, " busy_held"}, 64'(busy_ok), 64'd1);
    chk({tag, " hilo_held"}, 64'(hold_ok), 64'd1);
    chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({tag, " hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, " lo"}, 64'(bus.lo), 64'(el));
    chk({tag, " dbz"}, 64'(bus.div_by_zero), 64'(ez));
    if (idle_after) begin
      @(posedge clock); #1;
      chk({tag, " done_pulse_end"}, 64'(bus.done), 64'd0);
      chk({tag, " dbz_end"}, 64'(bus.div_by_zero), 64'd0);
      chk({tag, " hi_kept"}, 64'(bus.hi), 64'(eh));
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, eh, el;
    logic        ez;
  } vec_t;

  initial begin
    vec_t vecs[9];
    logic [1:0]  rop;
    logic [31:0] ra, rb, rh, rl;
    logic        rz;

    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{2'd3, 32'd100,        32'd7,        32'd2,        32'd14,        1'b0};
    vecs[4] = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[5] = '{2'd2, 32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0};
    vecs[6] = '{2'd2, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[8] = '{2'd3, 32'h8765_4321, 32'd0,        32'h8765_4321, 32'hFFFF_FFFF, 1'b1};

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.operand_a = 32'd0; bus.operand_b = 32'd0;
    bus.hi_write = 1'b0; bus.lo_write = 1'b0; bus.write_data = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset dbz", 64'(bus.div_by_zero), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    #3 reset = 1'b0;
    @(posedge clock); #1;

    // Directed cases with hand-derived expectations.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].ez,
             0, 1'b1, $sformatf("dir%0d", i));
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 28);
      ref_md(rop, ra, rb, rh, rl, rz);
      run_op(rop, ra, rb, rh, rl, rz, 0, 1'b1, $sformatf("rnd%0d", i));
    end

    // Start re-pulsed while busy and in FINISH is ignored.
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0,
           1, 1'b1, "repulse");
    // MTHI during busy is dropped.
    run_op(2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0,
           2, 1'b1, "mthi_busy");

    // MTHI alone, then MTHI+MTLO together, in IDLE.
    bus.hi_write = 1'b1; bus.write_data = 32'h0000_00AA;
    @(posedge clock); #1;
    bus.hi_write = 1'b0;
    chk("mthi idle hi", 64'(bus.hi), 64'h0000_00AA);
    chk("mthi idle lo", 64'(bus.lo), 64'h0000_0000);
    bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.write_data = 32'h0000_0055;
    @(posedge clock); #1;
    bus.hi_write = 1'b0; bus.lo_write = 1'b0;
    chk("mthilo hi", 64'(bus.hi), 64'h0000_0055);
    chk("mthilo lo", 64'(bus.lo), 64'h0000_0055);

    // Start and write in the same cycle: start wins (checked at the start edge).
    bus.hi_write = 1'b1; bus.write_data = 32'h0000_0077;
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 1'b1, "start_vs_write");

    // Back-to-back: second start issued in the done cycle.
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 1'b0, "chain_a");
    run_op(2'd2, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 0, 1'b1, "chain_b");

    // Asynchronous reset between edges during a DIVU.
    bus.start = 1'b1; bus.op = 2'd3; bus.operand_a = 32'd1000; bus.operand_b = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("async rst busy", 64'(bus.busy), 64'd0);
    chk("async rst done", 64'(bus.done), 64'd0);
    chk("async rst hi", 64'(bus.hi), 64'd0);
    chk("async rst lo", 64'(bus.lo), 64'd0);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    run_op(2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0, 1'b1, "after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
